// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA pixel timing: tick divider, h/v counters, sync/de decode, sync delay line
module vga_timing_gen #(
    parameter int DIV    = 4,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       hs_d,
    output logic       vs_d,
    output logic       de_d
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int DW      = $clog2(DIV);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pix_en_q, pix_en_d;
    logic [10:0]   h_cnt_q, h_cnt_d;
    logic [10:0]   v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d_int;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          tick;
    logic          h_act, v_act;

    assign tick = pix_en_q;

    always_comb begin
        div_cnt_d     = (div_cnt_q == DW'(DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        pix_en_d      = (div_cnt_q == DW'(DIV - 1));
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d_int      = de_q;
        x_d           = x_q;
        y_d           = y_q;
        // Strobes drop on any non-tick edge so they last a single clk
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_act = (h_cnt_q >= 11'(H_START)) && (h_cnt_q < 11'(H_START + H_ACT));
        v_act = (v_cnt_q >= 11'(V_START)) && (v_cnt_q < 11'(V_START + V_ACT));
        if (tick) begin
            hsync_d       = !(h_cnt_q < 11'(H_SYNC));
            vsync_d       = !(v_cnt_q < 11'(V_SYNC));
            de_d_int      = h_act && v_act;
            x_d           = (h_act && v_act) ? 10'(h_cnt_q - 11'(H_START)) : 10'd0;
            y_d           = (h_act && v_act) ? 10'(v_cnt_q - 11'(V_START)) : 10'd0;
            line_start_d  = (h_cnt_q == 11'd0);
            frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
            if (h_cnt_q == 11'(H_TOTAL - 1)) begin
                h_cnt_d = 11'd0;
                v_cnt_d = (v_cnt_q == 11'(V_TOTAL - 1)) ? 11'd0 : v_cnt_q + 11'd1;
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= '0;
            pix_en_q      <= 1'b0;
            h_cnt_q       <= 11'd0;
            v_cnt_q       <= 11'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_en_q      <= pix_en_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d_int;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

    // Delay line matches the renderer's pixel latency; bit 0 is the newest stage
    if (LAT == 0) begin : g_no_delay
        assign hs_d = hsync_q;
        assign vs_d = vsync_q;
        assign de_d = de_q;
    end else begin : g_delay
        logic [LAT-1:0] hs_pipe_q, hs_pipe_d;
        logic [LAT-1:0] vs_pipe_q, vs_pipe_d;
        logic [LAT-1:0] de_pipe_q, de_pipe_d;

        always_comb begin
            hs_pipe_d = hs_pipe_q;
            vs_pipe_d = vs_pipe_q;
            de_pipe_d = de_pipe_q;
            if (tick) begin
                hs_pipe_d = (hs_pipe_q << 1) | LAT'(hsync_q);
                vs_pipe_d = (vs_pipe_q << 1) | LAT'(vsync_q);
                de_pipe_d = (de_pipe_q << 1) | LAT'(de_q);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hs_pipe_q <= '1;
                vs_pipe_q <= '1;
                de_pipe_q <= '0;
            end else begin
                hs_pipe_q <= hs_pipe_d;
                vs_pipe_q <= vs_pipe_d;
                de_pipe_q <= de_pipe_d;
            end
        end

        assign hs_d = hs_pipe_q[LAT-1];
        assign vs_d = vs_pipe_q[LAT-1];
        assign de_d = de_pipe_q[LAT-1];
    end
endmodule
